// File: rtl/input_module_pkg.sv
`default_nettype none
// ============================================================================
// Module   : input_module_pkg
// Purpose  : Shared definitions for the router ingress port: flit type codes,
//            flit field bit positions, direction codes, FSM state encoding and
//            a direction-to-one-hot helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package input_module_pkg;

   localparam int c_FLIT_W = 10;
   localparam int c_DEPTH  = 32;
   localparam int c_PTR_W  = 5;
   localparam int c_CNT_W  = 6;
   localparam int c_NDIR   = 5;

   // Flit field bit positions
   localparam int c_TYPE_HI = 9;
   localparam int c_TYPE_LO = 8;
   localparam int c_DX_HI   = 7;
   localparam int c_DX_LO   = 6;
   localparam int c_DY_HI   = 5;
   localparam int c_DY_LO   = 4;

   typedef enum logic [1:0] {
      FT_BODY   = 2'b00,
      FT_HEAD   = 2'b01,
      FT_TAIL   = 2'b10,
      FT_SINGLE = 2'b11
   } flit_type_e;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   // Direction codes double as the bit index of write_en
   localparam logic [2:0] c_DIR_N = 3'd0;
   localparam logic [2:0] c_DIR_S = 3'd1;
   localparam logic [2:0] c_DIR_E = 3'd2;
   localparam logic [2:0] c_DIR_W = 3'd3;
   localparam logic [2:0] c_DIR_L = 3'd4;

   function automatic logic [c_NDIR-1:0] dir_onehot(input logic [2:0] dir);
      return 5'b00001 << dir;
   endfunction

endpackage
`default_nettype wire

// File: rtl/input_module_vc_buffer.sv
`default_nettype none
// ============================================================================
// Module   : input_module_vc_buffer
// Purpose  : 32-entry show-ahead FIFO used as the ingress flit buffer.
//            Head entry is presented combinationally on o_rdata.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            i_push/i_wdata - write request and data (ignored when full)
//            i_pop          - remove head entry (ignored when empty)
//            o_rdata        - head entry
//            o_empty/o_full - status flags
//            o_count        - occupancy 0..32
// Revision : 1.0 - initial release
// ============================================================================
module input_module_vc_buffer
   import input_module_pkg::*;
#(
   parameter int WIDTH = c_FLIT_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_push,
   input  logic [WIDTH-1:0]   i_wdata,
   input  logic               i_pop,
   output logic [WIDTH-1:0]   o_rdata,
   output logic               o_empty,
   output logic               o_full,
   output logic [c_CNT_W-1:0] o_count
);

   logic [WIDTH-1:0]   r_mem [c_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic               w_push_ok;
   logic               w_pop_ok;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_CNT_W'(c_DEPTH));
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_push_ok = i_push && !o_full;
   assign w_pop_ok  = i_pop && !o_empty;

   // Storage needs no reset; validity is tracked by the pointers and count
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers wrap naturally since the depth is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/input_module.sv
`default_nettype none
// ============================================================================
// Module   : input_module
// Purpose  : Router ingress port. Buffers incoming flits, XY-routes head and
//            single flits, holds a wormhole lock from head to tail and writes
//            each flit to one of five output modules through a two-stage
//            registered dispatch pipeline.
// Ports    : clk, reset  - clock, asynchronous active-high reset
//            data_in     - flit from upstream link, valid_in qualifies it
//            ready_out   - FIFO not full; accept on valid_in && ready_out
//            dn_space    - per direction {L,W,E,S,N}: target VC has room
//            data_out    - registered flit to output modules
//            write_en    - registered one-hot write strobe (bit = direction)
//            err_proto   - one-cycle framing error pulse
//            ocup        - FIFO occupancy
// Revision : 1.0 - initial release
// ============================================================================
module input_module
   import input_module_pkg::*;
#(
   parameter int unsigned X_ID   = 0,
   parameter int unsigned Y_ID   = 0,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned FLIT_W = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [FLIT_W-1:0]  data_in,
   input  logic               valid_in,
   output logic               ready_out,
   input  logic [c_NDIR-1:0]  dn_space,
   output logic [FLIT_W-1:0]  data_out,
   output logic [c_NDIR-1:0]  write_en,
   output logic               err_proto,
   output logic [c_CNT_W-1:0] ocup
);

   localparam logic [ADDR_W-1:0] c_X_ID = ADDR_W'(X_ID);
   localparam logic [ADDR_W-1:0] c_Y_ID = ADDR_W'(Y_ID);

   // Dimension-ordered XY routing: resolve X first, then Y
   function automatic logic [2:0] route(input logic [ADDR_W-1:0] dx,
                                        input logic [ADDR_W-1:0] dy);
      if (dx > c_X_ID)      return c_DIR_E;
      else if (dx < c_X_ID) return c_DIR_W;
      else if (dy > c_Y_ID) return c_DIR_N;
      else if (dy < c_Y_ID) return c_DIR_S;
      else                  return c_DIR_L;
   endfunction

   logic [FLIT_W-1:0] w_head;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   flit_type_e        w_type;
   logic [2:0]        w_route;
   logic [c_NDIR-1:0] w_we;
   logic              w_err;
   state_e            r_state;
   state_e            w_state_nxt;
   logic [2:0]        r_lock;
   logic [2:0]        w_lock_nxt;
   logic [c_NDIR-1:0] r_s1_we;
   logic [FLIT_W-1:0] r_s1_data;
   logic [c_NDIR-1:0] r_we;
   logic [FLIT_W-1:0] r_data;
   logic              r_err;

   input_module_vc_buffer #(
      .WIDTH (FLIT_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (valid_in),
      .i_wdata (data_in),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_full  (w_full),
      .o_count (ocup)
   );

   assign ready_out = !w_full;
   assign w_type    = flit_type_e'(w_head[c_TYPE_HI:c_TYPE_LO]);
   assign w_route   = route(w_head[c_DX_HI:c_DX_LO], w_head[c_DY_HI:c_DY_LO]);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_lock  <= c_DIR_N;
      end else begin
         r_state <= w_state_nxt;
         r_lock  <= w_lock_nxt;
      end
   end

   // Dispatch decision on the FIFO head. A blocked target leaves the flit in
   // place and the FSM untouched, so a stalled framing error is reported only
   // once, on the cycle the offending head actually leaves.
   always_comb begin
      w_state_nxt = r_state;
      w_lock_nxt  = r_lock;
      w_pop       = 1'b0;
      w_we        = '0;
      w_err       = 1'b0;
      if (!w_empty) begin
         case (w_type)
            FT_HEAD, FT_SINGLE: begin
               if (dn_space[w_route]) begin
                  w_pop = 1'b1;
                  w_we  = dir_onehot(w_route);
                  w_err = (r_state == ST_BUSY);
                  if (w_type == FT_HEAD) begin
                     w_state_nxt = ST_BUSY;
                     w_lock_nxt  = w_route;
                  end else begin
                     w_state_nxt = ST_IDLE;
                  end
               end
            end
            default: begin
               if (r_state == ST_IDLE) begin
                  // Orphan body/tail: drop it without writing anywhere
                  w_pop = 1'b1;
                  w_err = 1'b1;
               end else if (dn_space[r_lock]) begin
                  w_pop = 1'b1;
                  w_we  = dir_onehot(r_lock);
                  if (w_type == FT_TAIL) w_state_nxt = ST_IDLE;
               end
            end
         endcase
      end
   end

   // Two register stages between the FIFO head and the outputs; dn_space
   // reports two free slots so the extra in-flight flit cannot overrun.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_we   <= '0;
         r_s1_data <= '0;
         r_we      <= '0;
         r_data    <= '0;
         r_err     <= 1'b0;
      end else begin
         r_s1_we   <= w_we;
         r_s1_data <= w_head;
         r_err     <= w_err;
         r_we      <= r_s1_we;
         if (r_s1_we != '0) r_data <= r_s1_data;
      end
   end

   assign data_out  = r_data;
   assign write_en  = r_we;
   assign err_proto = r_err;

endmodule
`default_nettype wire
